// File: rtl/drain_counter.sv
// Down-counting token drain armed by load; issues LOAD_VAL tokens over valid/ready, pulses done when exhausted.
// Latency: tok_valid one edge after load is sampled. Backpressure: tok_ready=0 holds cnt/tok_valid indefinitely. Optional: DRAIN_RELOAD_EN.
module drain_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned LOAD_VAL = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             tok_ready,
  output logic             tok_valid,
  output logic [WIDTH-1:0] cnt,
  output logic             empty,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] LOAD_CNT = WIDTH'(LOAD_VAL);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  state_t state;

  assign empty = (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      tok_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (load) begin
            cnt       <= LOAD_CNT;
            state     <= DRAIN;
            tok_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end

        DRAIN: begin
`ifdef DRAIN_RELOAD_EN
          // Reload takes priority: a coincident accept is not decremented.
          if (load) begin
            cnt <= LOAD_CNT;
          end else if (tok_valid && tok_ready) begin
`else
          if (tok_valid && tok_ready) begin
`endif
            cnt <= cnt - ONE;
            if (cnt == ONE) begin
              state     <= DONE;
              tok_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end
          end
        end

        DONE: begin
          done <= 1'b0;
          if (load) begin
            cnt       <= LOAD_CNT;
            state     <= DRAIN;
            tok_valid <= 1'b1;
            busy      <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          cnt       <= '0;
          tok_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_drain_counter.sv
// Directed bench for drain_counter: reset, full drain, backpressure, back-to-back, mid-drain load, idle noise.
module tb_drain_counter;

  logic       clk;
  logic       rst;
  logic       load;
  logic       tok_ready;
  logic       tok_valid;
  logic [3:0] cnt;
  logic       empty;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  drain_counter #(.WIDTH(4), .LOAD_VAL(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .tok_ready (tok_ready),
    .tok_valid (tok_valid),
    .cnt       (cnt),
    .empty     (empty),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_cnt;
    int k;
    logic rdy;

    rst       = 1'b1;
    load      = 1'b0;
    tok_ready = 1'b0;
    #2;
    chk("rst_cnt",   cnt, 0);
    chk("rst_valid", tok_valid, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_empty", empty, 1);
    tick();
    rst = 1'b0;
    tick();

    // T2: basic drain with ready tied high
    load = 1'b1; tok_ready = 1'b1;
    tick();
    load = 1'b0;
    chk("t2_load_cnt", cnt, 15);
    chk("t2_valid",    tok_valid, 1);
    chk("t2_busy",     busy, 1);
    chk("t2_empty",    empty, 0);
    for (int i = 14; i >= 0; i--) begin
      tick();
      chk("t2_cnt", cnt, i);
    end
    chk("t2_done",     done, 1);
    chk("t2_done_vld", tok_valid, 0);
    chk("t2_done_bsy", busy, 0);
    chk("t2_empty0",   empty, 1);
    tick();
    chk("t2_done_off", done, 0);
    tick();
    chk("t2_idle_done", done, 0);
    chk("t2_idle_vld",  tok_valid, 0);

    // T6: ready noise while idle
    tok_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t6_idle", {cnt, tok_valid, done}, 0);
    end

    // T3: backpressure pattern 1,0,0,1,0,0...
    tok_ready = 1'b0;
    load = 1'b1;
    tick();
    load = 1'b0;
    exp_cnt = 15;
    k = 0;
    while (exp_cnt > 0 && k < 100) begin
      rdy = (k % 3 == 0);
      tok_ready = rdy;
      tick();
      if (rdy) exp_cnt--;
      chk("t3_cnt", cnt, exp_cnt);
      if (exp_cnt > 0) chk("t3_valid", tok_valid, 1);
      k++;
    end
    chk("t3_bound", (k < 100), 1);
    chk("t3_done", done, 1);
    tok_ready = 1'b0;
    tick();
    chk("t3_after", {busy, done, tok_valid}, 0);
    tick();

    // T4: back-to-back load during DONE
    tok_ready = 1'b1;
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("t4_done",  done, 1);
    chk("t4_cnt0",  cnt, 0);
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("t4_reload_cnt", cnt, 15);
    chk("t4_busy",       busy, 1);
    chk("t4_valid",      tok_valid, 1);
    chk("t4_done_off",   done, 0);

    // T5: load mid-drain at cnt=5
    for (int i = 0; i < 10; i++) tick();
    chk("t5_cnt5", cnt, 5);
    load = 1'b1;
    tick();
    load = 1'b0;
`ifdef DRAIN_RELOAD_EN
    chk("t5_reload", cnt, 15);
    for (int i = 14; i >= 0; i--) begin
      tick();
      chk("t5_cnt", cnt, i);
    end
`else
    chk("t5_ignored", cnt, 4);
    for (int i = 3; i >= 0; i--) begin
      tick();
      chk("t5_cnt", cnt, i);
    end
`endif
    chk("t5_done", done, 1);
    tick();
    chk("t5_idle", {busy, done, tok_valid}, 0);

    // T1: async reset mid-drain at cnt=7
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("t1_cnt7", cnt, 7);
    #2;
    rst = 1'b1;
    #1;
    chk("t1_valid", tok_valid, 0);
    chk("t1_busy",  busy, 0);
    chk("t1_cnt",   cnt, 0);
    chk("t1_empty", empty, 1);
    #2;
    rst = 1'b0;
    tick();
    chk("t1_idle", {busy, tok_valid, done, cnt}, 0);
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("t1_reload", cnt, 15);
    chk("t1_busy2",  busy, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
